// File: rtl/uart_fifo_ext.sv
// Parametrised synchronous FIFO for the UART TX/RX paths: any depth, FWFT or registered read,
// threshold flags, occupancy count, flush and sticky overflow/underflow flags.
module uart_fifo_ext #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  parameter  int FWFT     = 1,
  localparam int LW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] write_data,
  input  logic             pop,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_ok, pop_ok;

  // Status is decoded only from the registered level, so no push/pop path reaches it.
  assign empty        = (level_q == '0);
  assign full         = (level_q == LW'(DEPTH));
  assign almost_empty = (level_q <= LW'(AE_LEVEL));
  assign almost_full  = (level_q >= LW'(AF_LEVEL));
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Explicit wrap so non-power-of-two depths never index past the array.
      if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) level_d = level_q + 1'b1;
      if (pop_ok && !push_ok) level_d = level_q - 1'b1;
      if (push && !push_ok) overflow_d  = 1'b1;
      if (pop && empty)     underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push_ok) mem_q[wr_ptr_q] <= write_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign read_data  = mem_q[rd_ptr_q];
      assign read_valid = !empty;
    end else begin : g_regread
      logic [WIDTH-1:0] rdata_q;
      logic             rvalid_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else if (flush) begin
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= pop_ok;
          if (pop_ok) rdata_q <= mem_q[rd_ptr_q];
        end
      end
      assign read_data  = rdata_q;
      assign read_valid = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_uart_fifo_ext.sv
// Drives two FIFO instances (DEPTH=5 FWFT and DEPTH=4 registered-read) with shared stimulus
// and compares both against a shift-array occupancy model every cycle.
module tb_uart_fifo_ext;

  logic       clk;
  logic       rst_n, flush, push, pop, clr_err;
  logic [7:0] write_data;

  wire [7:0] rd0, rd1;
  wire       rv0, rv1, em0, em1, fu0, fu1, ae0, ae1, af0, af1, ov0, ov1, ud0, ud1;
  wire [2:0] lv0, lv1;

  uart_fifo_ext #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .write_data(write_data), .pop(pop),
    .read_data(rd0), .read_valid(rv0), .empty(em0), .full(fu0), .almost_empty(ae0),
    .almost_full(af0), .level(lv0), .overflow(ov0), .underflow(ud0), .clr_err(clr_err));

  uart_fifo_ext #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .write_data(write_data), .pop(pop),
    .read_data(rd1), .read_valid(rv1), .empty(em1), .full(fu1), .almost_empty(ae1),
    .almost_full(af1), .level(lv1), .overflow(ov1), .underflow(ud1), .clr_err(clr_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Reference model: contents kept as a list whose element 0 is the oldest word.
  int         mcnt [2];
  logic [7:0] mbuf [2][16];
  bit         movf [2], mudf [2], mrv [2];
  logic [7:0] mrd  [2];

  function automatic int dep(input int i);  return (i == 0) ? 5 : 4; endfunction
  function automatic bit fw(input int i);   return (i == 0);         endfunction
  function automatic int afl(input int i);  return 3;                endfunction
  function automatic int ael(input int i);  return (i == 0) ? 2 : 1; endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0h required=%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop_ok, push_ok;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mcnt[i] = 0; movf[i] = 0; mudf[i] = 0; mrv[i] = 0; mrd[i] = 8'h00;
      end else begin
        if (clr_err) begin movf[i] = 0; mudf[i] = 0; end
        if (flush) begin
          mcnt[i] = 0; mrv[i] = 0;
        end else begin
          pop_ok  = pop && (mcnt[i] > 0);
          push_ok = push && ((mcnt[i] < dep(i)) || pop_ok);
          if (push && !push_ok) movf[i] = 1;
          if (pop && mcnt[i] == 0) mudf[i] = 1;
          mrv[i] = 0;
          if (pop_ok) begin
            if (!fw(i)) begin mrd[i] = mbuf[i][0]; mrv[i] = 1; end
            for (int k = 0; k < 15; k++) mbuf[i][k] = mbuf[i][k+1];
            mcnt[i]--;
          end
          if (push_ok) begin mbuf[i][mcnt[i]] = write_data; mcnt[i]++; end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] rd; logic [2:0] lv; logic rv, em, fu, ae, af, ov, ud;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin rd = rd0; lv = lv0; rv = rv0; em = em0; fu = fu0; ae = ae0; af = af0; ov = ov0; ud = ud0; end
      else        begin rd = rd1; lv = lv1; rv = rv1; em = em1; fu = fu1; ae = ae1; af = af1; ov = ov1; ud = ud1; end
      chk("level", i, 32'(lv), 32'(mcnt[i]));
      chk("empty", i, 32'(em), 32'(mcnt[i] == 0));
      chk("full", i, 32'(fu), 32'(mcnt[i] == dep(i)));
      chk("almost_empty", i, 32'(ae), 32'(mcnt[i] <= ael(i)));
      chk("almost_full", i, 32'(af), 32'(mcnt[i] >= afl(i)));
      chk("overflow", i, 32'(ov), 32'(movf[i]));
      chk("underflow", i, 32'(ud), 32'(mudf[i]));
      chk("read_valid", i, 32'(rv), fw(i) ? 32'(mcnt[i] > 0) : 32'(mrv[i]));
      if (fw(i) && mcnt[i] > 0) chk("head_data", i, 32'(rd), 32'(mbuf[i][0]));
      if (!fw(i))               chk("read_data", i, 32'(rd), 32'(mrd[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (chk_en) check_all();
  endtask

  task automatic idle();
    flush = 0; push = 0; pop = 0; clr_err = 0;
  endtask

  typedef struct {
    bit         push;
    bit         pop;
    logic [7:0] wd;
    int         lvl;
    bit         full;
    bit         ovf;
    bit         chk_rd;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // DEPTH=5 FWFT instance: fill, overflow, push+pop at full, drain.
    tbl[0]  = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[1]  = '{1'b1, 1'b0, 8'h12, 2, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[2]  = '{1'b1, 1'b0, 8'h13, 3, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[3]  = '{1'b1, 1'b0, 8'h14, 4, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[4]  = '{1'b1, 1'b0, 8'h15, 5, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[5]  = '{1'b1, 1'b0, 8'h16, 5, 1'b1, 1'b1, 1'b1, 8'h11};
    tbl[6]  = '{1'b1, 1'b1, 8'hA0, 5, 1'b1, 1'b1, 1'b1, 8'h12};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 4, 1'b0, 1'b1, 1'b1, 8'h13};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b1, 1'b1, 8'h14};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b1, 1'b1, 8'h15};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 1'b1, 8'hA0};
    tbl[11] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'h00};

    rst_n = 0; write_data = 8'h00; idle();
    chk_en = 1;
    tick();
    chk("rst_read_data", 1, 32'(rd1), 32'h0);
    chk("rst_empty", 0, 32'(em0), 32'h1);
    rst_n = 1;

    // Three passes shift the pointers by 6 each time, crossing the wrap at index 4.
    for (int pass = 0; pass < 3; pass++) begin
      clr_err = 1; tick(); clr_err = 0;
      for (int r = 0; r < 12; r++) begin
        push = tbl[r].push; pop = tbl[r].pop; write_data = tbl[r].wd;
        tick();
        $display("pass %0d row %0d push=%0d pop=%0d wd=%h -> level=%0d full=%0b ovf=%0b rd=%h",
                 pass, r, push, pop, write_data, lv0, fu0, ov0, rd0);
        chk("tbl_level", 0, 32'(lv0), 32'(tbl[r].lvl));
        chk("tbl_full", 0, 32'(fu0), 32'(tbl[r].full));
        chk("tbl_empty", 0, 32'(em0), 32'(tbl[r].lvl == 0));
        chk("tbl_overflow", 0, 32'(ov0), 32'(tbl[r].ovf));
        if (tbl[r].chk_rd) chk("tbl_read_data", 0, 32'(rd0), 32'(tbl[r].rd));
      end
    end
    idle();

    // Registered read: data one cycle after pop, then held while read_valid drops.
    flush = 1; tick(); idle();
    push = 1; write_data = 8'h3C; tick(); idle();
    pop = 1; tick(); idle();
    chk("fwft0_valid", 1, 32'(rv1), 32'h1);
    chk("fwft0_data", 1, 32'(rd1), 32'h3C);
    tick();
    chk("fwft0_valid_drop", 1, 32'(rv1), 32'h0);
    chk("fwft0_data_hold", 1, 32'(rd1), 32'h3C);

    // Thresholds on DEPTH=4, AF=3, AE=1: walk the level up then down.
    flush = 1; tick(); idle();
    for (int k = 1; k <= 4; k++) begin
      push = 1; write_data = 8'(k); tick(); idle();
      chk("thr_up_ae", 1, 32'(ae1), 32'(k <= 1));
      chk("thr_up_af", 1, 32'(af1), 32'(k >= 3));
    end
    for (int k = 3; k >= 0; k--) begin
      pop = 1; tick(); idle();
      chk("thr_dn_ae", 1, 32'(ae1), 32'(k <= 1));
      chk("thr_dn_af", 1, 32'(af1), 32'(k >= 3));
    end

    // Underflow: set, set-wins-over-clear, then clear.
    clr_err = 1; tick(); idle();
    pop = 1; tick(); idle();
    chk("udf_set", 0, 32'(ud0), 32'h1);
    pop = 1; clr_err = 1; tick(); idle();
    chk("udf_set_wins", 0, 32'(ud0), 32'h1);
    clr_err = 1; tick(); idle();
    chk("udf_clear", 0, 32'(ud0), 32'h0);

    // Flush with a concurrent push at level 3.
    for (int k = 0; k < 3; k++) begin push = 1; write_data = 8'h40 + 8'(k); tick(); end
    idle();
    flush = 1; push = 1; write_data = 8'h55; tick(); idle();
    chk("flush_level", 0, 32'(lv0), 32'h0);
    chk("flush_empty", 0, 32'(em0), 32'h1);
    chk("flush_ovf", 0, 32'(ov0), 32'h0);
    chk("flush_udf", 0, 32'(ud0), 32'h0);
    push = 1; write_data = 8'h77; tick(); idle();
    chk("post_flush_head", 0, 32'(rd0), 32'h77);

    // Reset mid-operation at level 3.
    for (int k = 0; k < 2; k++) begin push = 1; write_data = 8'h60 + 8'(k); tick(); end
    idle();
    rst_n = 0; tick(); rst_n = 1;
    chk("rst_level", 0, 32'(lv0), 32'h0);
    chk("rst_ae", 0, 32'(ae0), 32'h1);
    chk("rst_af", 0, 32'(af0), 32'h0);
    chk("rst_rv", 1, 32'(rv1), 32'h0);
    chk("rst_rd", 1, 32'(rd1), 32'h0);
    push = 1; write_data = 8'h99; tick(); idle();
    chk("post_rst_level", 0, 32'(lv0), 32'h1);

    // Randomised traffic with fill/drain phases to reach full and empty often.
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 399) != 0);
      flush      = ($urandom_range(0, 59) == 0);
      clr_err    = ($urandom_range(0, 29) == 0);
      push       = ($urandom_range(0, 99) < (((n / 250) % 2 == 0) ? 75 : 30));
      pop        = ($urandom_range(0, 99) < (((n / 250) % 2 == 0) ? 30 : 75));
      write_data = 8'($urandom);
      tick();
    end
    rst_n = 1; idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
